// File: rtl/c_wrap_fifo_ctrl_if.sv
// Handshake and status bundle for the wrap-around FIFO controller.
// The master drives the request strobes; the slave (controller) drives the slot addresses and status.
interface c_wrap_fifo_ctrl_if #(
    parameter int addr_width = 4
);
    logic                  push;
    logic                  pop;
    logic [addr_width-1:0] write_addr;
    logic [addr_width-1:0] read_addr;
    logic [addr_width:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  push_err;
    logic                  pop_err;

    modport master (
        output push, pop,
        input  write_addr, read_addr, count, empty, full, almost_full, push_err, pop_err
    );

    modport slave (
        input  push, pop,
        output write_addr, read_addr, count, empty, full, almost_full, push_err, pop_err
    );
endinterface

// File: rtl/c_wrap_fifo_ctrl.sv
// Pointer/occupancy controller for a FIFO whose slots span [min_value, max_value].
// Status flags are decoded from the registered count, so they never depend combinationally on push/pop.
module c_wrap_fifo_ctrl #(
    parameter int addr_width = 4,
    parameter int min_value  = 4,
    parameter int max_value  = 7
) (
    input  logic                clk,
    input  logic                reset,
    c_wrap_fifo_ctrl_if.slave   bus
);
    localparam int CNT_W = addr_width + 1;
    localparam int DEPTH = max_value - min_value + 1;

    localparam logic [addr_width-1:0] MIN_ADDR   = addr_width'(min_value);
    localparam logic [addr_width-1:0] MAX_ADDR   = addr_width'(max_value);
    localparam logic [CNT_W-1:0]      DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      AFULL_CNT  = CNT_W'(DEPTH - 1);

    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  push_err_r;
    logic                  pop_err_r;

    logic                  is_empty;
    logic                  is_full;
    logic                  push_ok;
    logic                  pop_ok;
    logic [addr_width-1:0] wr_ptr_next;
    logic [addr_width-1:0] rd_ptr_next;
    logic [CNT_W-1:0]      cnt_next;

    // Modular step: wrap from the top slot straight back to the lowest one.
    function automatic logic [addr_width-1:0] wrap_next(input logic [addr_width-1:0] p);
        return (p == MAX_ADDR) ? MIN_ADDR : p + 1'b1;
    endfunction

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == DEPTH_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    assign push_ok = bus.push && (!is_full || bus.pop);
    assign pop_ok  = bus.pop && !is_empty;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        cnt_next    = cnt;
        if (push_ok) begin
            wr_ptr_next = wrap_next(wr_ptr);
        end
        if (pop_ok) begin
            rd_ptr_next = wrap_next(rd_ptr);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_next = cnt + 1'b1;
            2'b01:   cnt_next = cnt - 1'b1;
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= MIN_ADDR;
            rd_ptr     <= MIN_ADDR;
            cnt        <= '0;
            push_err_r <= 1'b0;
            pop_err_r  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            cnt        <= cnt_next;
            push_err_r <= bus.push && is_full && !bus.pop;
            pop_err_r  <= bus.pop && is_empty;
        end
    end

    assign bus.write_addr  = wr_ptr;
    assign bus.read_addr   = rd_ptr;
    assign bus.count       = cnt;
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.almost_full = (cnt == AFULL_CNT);
    assign bus.push_err    = push_err_r;
    assign bus.pop_err     = pop_err_r;
endmodule
